// File: rtl/uart_tx_path.sv
// -----------------------------------------------------------------------------
// uart_tx_path
//
// UART transmit path: a DEPTH-entry byte FIFO feeding an 8N1 serializer with
// an internal baud divider. The processor side pushes bytes with a load strobe.
// The serializer pops the head byte whenever it is free. A pop happens when
// the serializer leaves IDLE, or at the end of a stop bit, which gives
// back-to-back frames with no idle gap.
//
// Optional feature, macro UART_TX_PARITY_EN:
//   defined   - a PARITY state sits between DATA and STOP. It sends the even
//               parity bit (XOR of the 8 data bits), so frames are 11 bits.
//   undefined - 8N1 frames only (10 bits).
//
// Parameters:
//   DEPTH        FIFO entries (power of 2, >= 2)
//   CLKS_PER_BIT sys_clk cycles per serial bit (>= 2)
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   fifo_data_in in   [7:0] byte to enqueue
//   ld_tx_fifo   in   push strobe, sampled every rising edge
//   tx           out  serial line, idle high
//   full         out  FIFO holds DEPTH entries
//   data_valid   out  FIFO non-empty
//   transmitting out  serializer busy with a frame
//
// All outputs are decoded from registers only. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module uart_tx_path #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] fifo_data_in,
    input  logic       ld_tx_fifo,
    output logic       tx,
    output logic       full,
    output logic       data_valid,
    output logic       transmitting
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Serializer state
    logic [2:0]        r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic       w_push;
    logic       w_pop;
    logic       w_bit_done;
    logic [7:0] w_head;

    assign full         = (r_count == FULL_CNT);
    assign data_valid   = (r_count != '0);
    assign transmitting = (r_state != ST_IDLE);

    // full gates the push even when a pop happens in the same cycle.
    assign w_push     = ld_tx_fifo && !full;
    assign w_bit_done = (r_baud_cnt == BAUD_LAST);
    assign w_pop      = data_valid &&
                        ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));
    assign w_head     = r_mem[r_rd_ptr];

    // NOTE: storage arrays carry no reset; the count and pointers decide
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_data_in;
        end
    end

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer FSM. The baud counter restarts at 0 on every state entry.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^w_head;
`endif
                        r_state    <= ST_START;
                        r_baud_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (w_bit_done) begin
                        r_state    <= ST_DATA;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        // LSB goes out first; shift the next bit into place.
                        r_shift    <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_state    <= ST_STOP;
                        r_baud_cnt <= '0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            // Chain straight into the next frame.
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_state  <= ST_START;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    // NOTE: tx gets a default before the case so that no latch is inferred.
    always_comb begin
        tx = 1'b1;
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = r_parity;
`endif
            default:   tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_path.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_path
//
// Directed bench for uart_tx_path with DEPTH=8, CLKS_PER_BIT=10. Inputs are
// driven and outputs sampled on the falling edge of sys_clk. Define
// UART_TX_PARITY_EN for both files to exercise the parity frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_path;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sys_clk;
    logic       rst;
    logic [7:0] fifo_data_in;
    logic       ld_tx_fifo;
    logic       tx;
    logic       full;
    logic       data_valid;
    logic       transmitting;

    int n_checks = 0;
    int n_fail   = 0;

    // Values sampled by check_frame at the first and last cycle of a frame
    logic st_dv;
    logic st_full;
    logic end_full;

    uart_tx_path #(
        .DEPTH        (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .fifo_data_in (fifo_data_in),
        .ld_tx_fifo   (ld_tx_fifo),
        .tx           (tx),
        .full         (full),
        .data_valid   (data_valid),
        .transmitting (transmitting)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Expected line sequence, element 0 first on the wire: start, d0..d7,
    // [parity], stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, 1'b1, b, 1'b0};
`endif
    endfunction

    // Waits up to 'timeout' cycles for the start bit, then requires every
    // bit to hold for exactly CPB cycles with transmitting high. Returns at
    // the first cycle after the frame.
    task automatic check_frame(input string name, input logic [10:0] exp, input int timeout);
        int   w;
        logic bit_ok;
        logic last_tx;
        w = 0;
        while (tx !== 1'b0 && w < timeout) begin
            @(negedge sys_clk);
            w++;
        end
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: tx=%b after %0d cycles, required 0", name, tx, w);
            return;
        end
        st_dv    = data_valid;
        st_full  = full;
        end_full = 1'bx;
        for (int i = 0; i < NBITS; i++) begin
            bit_ok  = 1'b1;
            last_tx = tx;
            for (int c = 0; c < CPB; c++) begin
                if (tx !== exp[i] || transmitting !== 1'b1) begin
                    bit_ok  = 1'b0;
                    last_tx = tx;
                end
                if (i == NBITS - 1 && c == CPB - 1) end_full = full;
                @(negedge sys_clk);
            end
            n_checks++;
            if (!bit_ok) begin
                n_fail++;
                $display("FAIL %s bit %0d: saw tx=%b or transmitting low, required tx=%b and transmitting=1 for %0d cycles",
                         name, i, last_tx, exp[i], CPB);
            end
        end
    endtask

    task automatic expect_idle(input string name);
        n_checks++;
        if (tx !== 1'b1 || transmitting !== 1'b0 || data_valid !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: tx=%b transmitting=%b data_valid=%b full=%b, required 1 0 0 0",
                     name, tx, transmitting, data_valid, full);
        end
    endtask

    // Requires the line to stay idle with an empty FIFO for n cycles.
    task automatic expect_quiet(input string name, input int n);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < n; c++) begin
            if (tx !== 1'b1 || transmitting !== 1'b0 || data_valid !== 1'b0) ok = 1'b0;
            @(negedge sys_clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: activity seen within %0d idle cycles, required tx=1 transmitting=0 data_valid=0",
                     name, n);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        ld_tx_fifo   = 1'b0;
        fifo_data_in = 8'h00;
        repeat (2) @(negedge sys_clk);
        expect_idle("reset_held");
        rst = 1'b1;
        @(negedge sys_clk);
        expect_idle("reset_released");
        expect_quiet("reset_no_activity", 20);
    endtask

    task automatic test_single();
        fifo_data_in = 8'h55;
        ld_tx_fifo   = 1'b1;
        @(negedge sys_clk);
        ld_tx_fifo   = 1'b0;
        // After push edge N: queued, line still idle
        n_checks++;
        if (data_valid !== 1'b1 || tx !== 1'b1 || transmitting !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_push: data_valid=%b tx=%b transmitting=%b, required 1 1 0",
                     data_valid, tx, transmitting);
        end
        @(negedge sys_clk);
        // After edge N+1: popped, start bit on the line
        n_checks++;
        if (data_valid !== 1'b0 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: data_valid=%b tx=%b, required 0 0", data_valid, tx);
        end
        check_frame("single_0x55", make_frame(8'h55), 0);
        expect_idle("single_end");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5];
        bytes[0] = 8'h55;
        bytes[1] = 8'hF0;
        bytes[2] = 8'h0F;
        bytes[3] = 8'hAA;
        bytes[4] = 8'h55;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    fifo_data_in = bytes[i];
                    ld_tx_fifo   = 1'b1;
                    @(negedge sys_clk);
                end
                ld_tx_fifo = 1'b0;
            end
            begin
                @(negedge sys_clk);
                for (int i = 0; i < 5; i++) begin
                    check_frame($sformatf("burst_frame%0d", i), make_frame(bytes[i]), (i == 0) ? 3 : 0);
                    if (i == 3) begin
                        n_checks++;
                        if (st_dv !== 1'b1) begin
                            n_fail++;
                            $display("FAIL burst_dv_before_last_pop: data_valid=%b, required 1", st_dv);
                        end
                    end
                    if (i == 4) begin
                        n_checks++;
                        if (st_dv !== 1'b0) begin
                            n_fail++;
                            $display("FAIL burst_dv_after_last_pop: data_valid=%b, required 0", st_dv);
                        end
                    end
                end
            end
        join
        expect_idle("burst_end");
    endtask

    task automatic test_overflow();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    fifo_data_in = 8'(i);
                    ld_tx_fifo   = 1'b1;
                    @(negedge sys_clk);
                    if (i >= 7) begin
                        n_checks++;
                        if (full !== (i >= 8)) begin
                            n_fail++;
                            $display("FAIL overflow_full_after_push%0d: full=%b, required %b",
                                     i, full, (i >= 8));
                        end
                    end
                end
                ld_tx_fifo = 1'b0;
            end
            begin
                @(negedge sys_clk);
                for (int i = 0; i < 9; i++) begin
                    check_frame($sformatf("overflow_byte%0d", i), make_frame(8'(i)), (i == 0) ? 3 : 0);
                    if (i == 0) begin
                        n_checks++;
                        if (end_full !== 1'b1) begin
                            n_fail++;
                            $display("FAIL overflow_full_before_pop: full=%b, required 1", end_full);
                        end
                    end
                    if (i == 1) begin
                        n_checks++;
                        if (st_full !== 1'b0) begin
                            n_fail++;
                            $display("FAIL overflow_full_after_pop: full=%b, required 0", st_full);
                        end
                    end
                end
            end
        join
        // 0x09 was dropped: nothing else may go out
        expect_quiet("overflow_dropped", 30);
    endtask

    task automatic test_reset_mid_frame();
        fifo_data_in = 8'h55; ld_tx_fifo = 1'b1; @(negedge sys_clk);
        fifo_data_in = 8'hAA;                    @(negedge sys_clk);
        fifo_data_in = 8'h0F;                    @(negedge sys_clk);
        ld_tx_fifo = 1'b0;
        // Start bit began one cycle ago; move to cycle 45 (data bit 3)
        repeat (44) @(negedge sys_clk);
        n_checks++;
        if (tx !== 1'b0 || transmitting !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_before: tx=%b transmitting=%b, required 0 1", tx, transmitting);
        end
        #2 rst = 1'b0;
        #1;
        expect_idle("midreset_async");
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        expect_quiet("midreset_flushed", 150);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        fifo_data_in = 8'h07;
        ld_tx_fifo   = 1'b1;
        @(negedge sys_clk);
        ld_tx_fifo   = 1'b0;
        // 0,1,1,1,0,0,0,0,0, parity 1, stop 1
        check_frame("parity_0x07", 11'b110_0000_1110, 3);
        expect_idle("parity_0x07_end");
        fifo_data_in = 8'h03;
        ld_tx_fifo   = 1'b1;
        @(negedge sys_clk);
        ld_tx_fifo   = 1'b0;
        // 0,1,1,0,0,0,0,0,0, parity 0, stop 1
        check_frame("parity_0x03", 11'b100_0000_0110, 3);
        expect_idle("parity_0x03_end");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
